// File: rtl/timer_bank_ctrl_pkg.sv
// Shared definitions for the timer bank controller: FSM encoding, register map, helpers.
// Optional macro TIMER_BANK_VECTOR_EN enables the registered IRQ vector output.
package timer_bank_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOT = 2'd1,
        CTRL = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [1:0] REG_PEND   = 2'd0;
    localparam logic [1:0] REG_MASK   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_ERR    = 2'd3;

    localparam logic [3:0] CTRL_SLOT = 4'd15;
    localparam int         OVF_OFS   = 16;

    // Returns the position of the lowest set bit, or 6'h3F when the vector is empty.
    function automatic logic [5:0] lowest_set(input logic [31:0] v);
        logic [5:0] idx;
        idx = 6'h3F;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = 6'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/timer_bank_irq.sv
// Pending/mask/error storage and IRQ generation for the timer bank controller.
// Macro TIMER_BANK_VECTOR_EN adds the registered irq_vec_o encoder.
import timer_bank_ctrl_pkg::*;

module timer_bank_irq #(
    parameter int NUM_TIMERS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_TIMERS-1:0] match_i,
    input  logic [NUM_TIMERS-1:0] ovf_i,
    input  logic                  wr_i,
    input  logic [1:0]            reg_i,
    input  logic [31:0]           wdata_i,
    input  logic [1:0]            err_set_i,
    output logic [31:0]           rdata_o,
`ifdef TIMER_BANK_VECTOR_EN
    output logic [5:0]            irq_vec_o,
`endif
    output logic                  irq_o
);

    localparam logic [31:0] TMR_BITS = 32'((64'd1 << NUM_TIMERS) - 64'd1);
    localparam logic [31:0] VALID    = TMR_BITS | (TMR_BITS << OVF_OFS);

    logic [31:0] pend_q, pend_d, mask_q, mask_d, set_vec, pend_clr, status;
    logic [1:0]  err_q, err_d, err_clr;
    logic        irq_q;

    // Clear is applied before set so a pulse in the same cycle as a W1C survives.
    always_comb begin
        set_vec  = (32'(match_i) | (32'(ovf_i) << OVF_OFS)) & VALID;
        pend_clr = (wr_i && reg_i == REG_PEND) ? (wdata_i & VALID) : 32'd0;
        pend_d   = (pend_q & ~pend_clr) | set_vec;
        mask_d   = (wr_i && reg_i == REG_MASK) ? (wdata_i & VALID) : mask_q;
        err_clr  = (wr_i && reg_i == REG_ERR) ? wdata_i[1:0] : 2'b00;
        err_d    = (err_q & ~err_clr) | err_set_i;
        status   = pend_q & mask_q;
    end

`ifdef TIMER_BANK_VECTOR_EN
    logic [5:0] vec_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) vec_q <= 6'h3F;
        else         vec_q <= lowest_set(status);
    end

    assign irq_vec_o = vec_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= 32'd0;
            mask_q <= 32'd0;
            err_q  <= 2'b00;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            err_q  <= err_d;
            irq_q  <= |status;
        end
    end

    always_comb begin
        rdata_o = 32'd0;
        case (reg_i)
            REG_PEND:   rdata_o = pend_q;
            REG_MASK:   rdata_o = mask_q;
`ifdef TIMER_BANK_VECTOR_EN
            REG_STATUS: rdata_o = {vec_q, status[25:0]};
`else
            REG_STATUS: rdata_o = status;
`endif
            default:    rdata_o = {30'd0, err_q};
        endcase
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/timer_bank_ctrl.sv
// Bus-side controller for a bank of timer slots: address decode, access FSM with timeout, IRQ.
// Macro TIMER_BANK_VECTOR_EN adds the irq_vec_o output and STATUS[31:26] vector field.
import timer_bank_ctrl_pkg::*;

module timer_bank_ctrl #(
    parameter int NUM_TIMERS     = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     stb_i,
    input  logic                     we_i,
    input  logic [5:0]               addr_i,
    input  logic [31:0]              dtw_i,
    output logic [31:0]              dtr_o,
    output logic                     ack_o,
    output logic [NUM_TIMERS-1:0]    t_stb_o,
    output logic [NUM_TIMERS-1:0]    t_we_o,
    output logic [1:0]               t_addr_o,
    output logic [31:0]              t_dtw_o,
    input  logic [32*NUM_TIMERS-1:0] t_dtr_i,
    input  logic [NUM_TIMERS-1:0]    t_ack_i,
    input  logic [NUM_TIMERS-1:0]    t_int_match_i,
    input  logic [NUM_TIMERS-1:0]    t_int_ovf_i,
`ifdef TIMER_BANK_VECTOR_EN
    output logic [5:0]               irq_vec_o,
`endif
    output logic                     irq_o
);

    state_e                state_q, state_d;
    logic [3:0]            slot_q, slot_d;
    logic                  we_q, we_d, ack_q, ack_d;
    logic [1:0]            t_addr_q, t_addr_d;
    logic [31:0]           t_dtw_q, t_dtw_d, dtr_q, dtr_d;
    logic [NUM_TIMERS-1:0] t_stb_q, t_stb_d, t_we_q, t_we_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  sel_ack, ctrl_wr;
    logic [31:0]           sel_dtr, ctrl_rdata;
    logic [1:0]            err_set;

    always_comb begin
        sel_ack = 1'b0;
        sel_dtr = 32'd0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (slot_q == 4'(i)) begin
                sel_ack = t_ack_i[i];
                sel_dtr = t_dtr_i[32*i +: 32];
            end
        end
    end

    // Next-state and registered-output logic; every transition into RESP raises ack for one cycle.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        we_d     = we_q;
        ack_d    = 1'b0;
        t_addr_d = t_addr_q;
        t_dtw_d  = t_dtw_q;
        dtr_d    = dtr_q;
        t_stb_d  = t_stb_q;
        t_we_d   = t_we_q;
        cnt_d    = cnt_q;
        ctrl_wr  = 1'b0;
        err_set  = 2'b00;
        case (state_q)
            IDLE: begin
                if (stb_i) begin
                    slot_d   = addr_i[5:2];
                    t_addr_d = addr_i[1:0];
                    t_dtw_d  = dtw_i;
                    we_d     = we_i;
                    cnt_d    = 8'd0;
                    if ({1'b0, addr_i[5:2]} < 5'(NUM_TIMERS)) begin
                        for (int i = 0; i < NUM_TIMERS; i++) begin
                            t_stb_d[i] = (addr_i[5:2] == 4'(i));
                            t_we_d[i]  = (addr_i[5:2] == 4'(i)) && we_i;
                        end
                        state_d = SLOT;
                    end else if (addr_i[5:2] == CTRL_SLOT) begin
                        state_d = CTRL;
                    end else begin
                        dtr_d      = 32'd0;
                        err_set[0] = 1'b1;
                        ack_d      = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            SLOT: begin
                if (sel_ack) begin
                    dtr_d   = sel_dtr;
                    t_stb_d = '0;
                    t_we_d  = '0;
                    ack_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    dtr_d      = 32'd0;
                    t_stb_d    = '0;
                    t_we_d     = '0;
                    err_set[1] = 1'b1;
                    ack_d      = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CTRL: begin
                ctrl_wr = we_q;
                dtr_d   = ctrl_rdata;
                ack_d   = 1'b1;
                state_d = RESP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            slot_q   <= 4'd0;
            we_q     <= 1'b0;
            ack_q    <= 1'b0;
            t_addr_q <= 2'd0;
            t_dtw_q  <= 32'd0;
            dtr_q    <= 32'd0;
            t_stb_q  <= '0;
            t_we_q   <= '0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            we_q     <= we_d;
            ack_q    <= ack_d;
            t_addr_q <= t_addr_d;
            t_dtw_q  <= t_dtw_d;
            dtr_q    <= dtr_d;
            t_stb_q  <= t_stb_d;
            t_we_q   <= t_we_d;
            cnt_q    <= cnt_d;
        end
    end

    timer_bank_irq #(
        .NUM_TIMERS (NUM_TIMERS)
    ) u_irq (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .match_i   (t_int_match_i),
        .ovf_i     (t_int_ovf_i),
        .wr_i      (ctrl_wr),
        .reg_i     (t_addr_q),
        .wdata_i   (t_dtw_q),
        .err_set_i (err_set),
        .rdata_o   (ctrl_rdata),
`ifdef TIMER_BANK_VECTOR_EN
        .irq_vec_o (irq_vec_o),
`endif
        .irq_o     (irq_o)
    );

    assign dtr_o    = dtr_q;
    assign ack_o    = ack_q;
    assign t_stb_o  = t_stb_q;
    assign t_we_o   = t_we_q;
    assign t_addr_o = t_addr_q;
    assign t_dtw_o  = t_dtw_q;

endmodule
